// File: rtl/reg_file_bank_if.sv
// Bus bundle between the decode/control stage and the register file bank.
// The master drives addresses, write data and clear; the bank returns operands and status.
interface reg_file_bank_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  localparam int DEPTH = 1 << AW;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    dat_in;
  logic [AW-1:0]    rd_addrA;
  logic [AW-1:0]    rd_addrB;
  logic             clr_req;
  logic [DW-1:0]    datA_out;
  logic [DW-1:0]    datB_out;
  logic             wr_ack;
  logic             busy;
  logic [DEPTH-1:0] dirty;

  modport master (
    output wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
    input  datA_out, datB_out, wr_ack, busy, dirty
  );

  modport slave (
    input  wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
    output datA_out, datB_out, wr_ack, busy, dirty
  );
endinterface

// File: rtl/reg_file_bank.sv
// Parametrised register file: 2 combinational read ports, 1 write port,
// per-entry dirty flags and a one-entry-per-cycle hardware clear sweep.
module rfb_entry #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          clr_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          dirty_o
);
  logic [DW-1:0] data_q;
  logic          dirty_q;

  // Clear and write are never both asserted: writes are refused while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dirty_q <= 1'b0;
    end else if (clr_i) begin
      data_q  <= '0;
      dirty_q <= 1'b0;
    end else if (we_i) begin
      data_q  <= d_i;
      dirty_q <= 1'b1;
    end
  end

  assign q_o     = data_q;
  assign dirty_o = dirty_q;
endmodule

module reg_file_bank #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_bank_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                     state_q;
  logic [AW-1:0]              ptr_q;
  logic                       busy_q;
  logic [DEPTH-1:0][DW-1:0]   core;
  logic [DEPTH-1:0]           dirty;
  logic                       wr_ack;
  logic                       zero_a, zero_b, byp_a, byp_b;

  assign wr_ack = bus.wr_en & ~busy_q &
                  ~((ZERO_R0 != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          // ptr wraps to 0 on the same edge the sweep finishes
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rfb_entry #(.DW(DW)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_ack && (bus.wr_addr == AW'(i))),
      .clr_i   (busy_q && (ptr_q == AW'(i))),
      .d_i     (bus.dat_in),
      .q_o     (core[i]),
      .dirty_o (dirty[i])
    );
  end

  assign zero_a = (ZERO_R0 != 0) && (bus.rd_addrA == '0);
  assign zero_b = (ZERO_R0 != 0) && (bus.rd_addrB == '0);
  assign byp_a  = (BYPASS != 0) && wr_ack && (bus.wr_addr == bus.rd_addrA);
  assign byp_b  = (BYPASS != 0) && wr_ack && (bus.wr_addr == bus.rd_addrB);

  assign bus.datA_out = zero_a ? '0 : byp_a ? bus.dat_in : core[bus.rd_addrA];
  assign bus.datB_out = zero_b ? '0 : byp_b ? bus.dat_in : core[bus.rd_addrB];
  assign bus.wr_ack   = wr_ack;
  assign bus.busy     = busy_q;
  assign bus.dirty    = dirty;
endmodule
